radix_min_sorter: RTL and testbench

Sequential radix sorter for the min-sort path. It accepts a batch of M keys, each W bits wide, in one handshake. It then emits the keys one per handshake in ascending order (or descending, if DESCEND=1), each with its original slot index. Each extraction runs an MSB-first bitwise elimination over the still-unsorted keys, one bit per clock, and finishes with a lowest-index priority pick. This is the iterative, streaming successor to the single-shot combinational select stage.

---
 rtl/radix_min_sorter.sv | 148 ++++++++++++++
 tb/tb_radix_min_sorter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/radix_min_sorter.sv
// Streaming radix sorter: loads M keys, then emits them one per handshake in sorted order
// with their slot index, using an MSB-first bit-elimination scan per extracted element.
module radix_min_sorter #(
   parameter int M       = 8,
   parameter int W       = 16,
   parameter int DESCEND = 0,
   localparam int IDXW   = $clog2(M)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [M-1:0][W-1:0]   i_keys,
   input  logic [M-1:0]          i_mask,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [W-1:0]          o_key,
   output logic [IDXW-1:0]       o_idx,
   output logic                  o_last,
   output logic                  o_busy
);

   localparam int BW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

   state_t            state_reg, state_next;
   logic [W-1:0]      keys_reg [M];
   logic [M-1:0]      r_reg, r_next;
   logic [M-1:0]      a_reg, a_next;
   logic [BW-1:0]     b_reg, b_next;
   logic [W-1:0]      key_reg, key_next;
   logic [IDXW-1:0]   idx_reg, idx_next;
   logic              last_reg, last_next;

   logic [M-1:0]      bitcol;
   logic [M-1:0]      z;
   logic [M-1:0]      a_upd;
   logic [M-1:0]      r_drop;
   logic [IDXW-1:0]   sel;
   logic              r_single;
   logic              load;

   assign load = (state_reg == IDLE) && i_valid;

   genvar gi;
   generate
      for (gi = 0; gi < M; gi++) begin : g_slot
         assign bitcol[gi] = keys_reg[gi][b_reg];

         always_ff @(posedge i_clk) begin
            if (load) begin
               keys_reg[gi] <= i_keys[gi];
            end
         end
      end
   endgenerate

   // Survivors keep the preferred bit value; if nobody has it, everyone survives.
   assign z     = (DESCEND != 0) ? (a_reg & bitcol) : (a_reg & ~bitcol);
   assign a_upd = (z != '0) ? z : a_reg;

   always_comb begin
      sel = '0;
      for (int i = M - 1; i >= 0; i--) begin
         if (a_upd[i]) begin
            sel = IDXW'(i);
         end
      end
   end

   assign r_drop   = r_reg & ~(M'(1) << idx_reg);
   assign r_single = (r_reg != '0) && ((r_reg & (r_reg - M'(1))) == '0);

   always_comb begin
      state_next = state_reg;
      r_next     = r_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      key_next   = key_reg;
      idx_next   = idx_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (i_valid) begin
               r_next = i_mask;
               if (i_mask != '0) begin
                  a_next     = i_mask;
                  b_next     = BW'(W - 1);
                  state_next = SCAN;
               end
            end
         end
         SCAN: begin
            a_next = a_upd;
            if (b_reg != '0) begin
               b_next = b_reg - BW'(1);
            end else begin
               key_next   = keys_reg[sel];
               idx_next   = sel;
               last_next  = r_single;
               state_next = OUT;
            end
         end
         OUT: begin
            if (i_ready) begin
               r_next = r_drop;
               if (r_drop == '0) begin
                  state_next = IDLE;
               end else begin
                  a_next     = r_drop;
                  b_next     = BW'(W - 1);
                  state_next = SCAN;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg <= IDLE;
         r_reg     <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         key_reg   <= '0;
         idx_reg   <= '0;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         r_reg     <= r_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         key_reg   <= key_next;
         idx_reg   <= idx_next;
         last_reg  <= last_next;
      end
   end

   assign o_ready = (state_reg == IDLE);
   assign o_busy  = (state_reg != IDLE);
   assign o_valid = (state_reg == OUT);
   assign o_key   = key_reg;
   assign o_idx   = idx_reg;
   assign o_last  = (state_reg == OUT) && last_reg;

endmodule

// File: tb/tb_radix_min_sorter.sv
// Scoreboard bench for radix_min_sorter: an ascending and a descending instance share
// the stimulus; a monitor pops expected elements on every output handshake.
module tb_radix_min_sorter;

   localparam int M = 4;
   localparam int W = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               i_valid = 1'b0;
   logic [M-1:0][W-1:0] i_keys = '0;
   logic [M-1:0]       i_mask = '0;
   logic               i_ready = 1'b0;
   logic               use_desc = 1'b0;

   logic               a_ready, a_valid, a_last, a_busy;
   logic [W-1:0]       a_key;
   logic [1:0]         a_idx;
   logic               d_ready, d_valid, d_last, d_busy;
   logic [W-1:0]       d_key;
   logic [1:0]         d_idx;

   logic               o_ready, o_valid, o_last, o_busy;
   logic [W-1:0]       o_key;
   logic [1:0]         o_idx;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] key;
      logic [1:0]   idx;
      logic         last;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   radix_min_sorter #(.M(M), .W(W), .DESCEND(0)) dut_asc (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid & ~use_desc), .o_ready(a_ready),
      .i_keys(i_keys), .i_mask(i_mask), .o_valid(a_valid), .i_ready(i_ready),
      .o_key(a_key), .o_idx(a_idx), .o_last(a_last), .o_busy(a_busy)
   );

   radix_min_sorter #(.M(M), .W(W), .DESCEND(1)) dut_dsc (
      .i_clk(clk), .i_rst(rst), .i_valid(i_valid & use_desc), .o_ready(d_ready),
      .i_keys(i_keys), .i_mask(i_mask), .o_valid(d_valid), .i_ready(i_ready),
      .o_key(d_key), .o_idx(d_idx), .o_last(d_last), .o_busy(d_busy)
   );

   assign o_ready = use_desc ? d_ready : a_ready;
   assign o_valid = use_desc ? d_valid : a_valid;
   assign o_last  = use_desc ? d_last  : a_last;
   assign o_busy  = use_desc ? d_busy  : a_busy;
   assign o_key   = use_desc ? d_key   : a_key;
   assign o_idx   = use_desc ? d_idx   : a_idx;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int key, input int idx, input bit last);
      exp_t e;
      e.key  = W'(key);
      e.idx  = 2'(idx);
      e.last = last;
      sb.push_back(e);
   endtask

   // Monitor: a handshake happens at the next rising edge when valid and ready are both high.
   always @(negedge clk) begin
      if (!rst && o_valid && i_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_out: got key %0d idx %0d, required no element", o_key, o_idx);
         end else begin
            exp_t e;
            e = sb.pop_front();
            $display("[TB] out key=%0d idx=%0d last=%0d (exp %0d,%0d,%0d)",
                     o_key, o_idx, o_last, e.key, e.idx, e.last);
            chk("out_key", 32'(o_key), 32'(e.key));
            chk("out_idx", 32'(o_idx), 32'(e.idx));
            chk("out_last", 32'(o_last), 32'(e.last));
         end
      end
   end

   task automatic load(input int k0, input int k1, input int k2, input int k3, input logic [3:0] m);
      @(negedge clk);
      chk("load_ready", 32'(o_ready), 1);
      i_keys[0] = W'(k0);
      i_keys[1] = W'(k1);
      i_keys[2] = W'(k2);
      i_keys[3] = W'(k3);
      i_mask    = m;
      i_valid   = 1'b1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (o_ready) begin
            done = 1'b1;
            break;
         end
      end
      chk(nm, 32'(done), 1);
   endtask

   task automatic wait_valid(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk(nm, 32'(seen), 1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(o_ready), 1);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_key", 32'(o_key), 0);
      chk("rst_idx", 32'(o_idx), 0);
      chk("rst_last", 32'(o_last), 0);

      // Test 1: ascending, full mask, timing
      i_ready = 1'b1;
      push(1, 3, 0); push(3, 0, 0); push(3, 2, 0); push(9, 1, 1);
      load(3, 9, 3, 1, 4'b1111);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); n++; #1;
         if (o_valid) break;
      end
      chk("first_valid_latency", 32'(n), 4);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); n++; #1;
         if (o_ready) break;
      end
      chk("batch_cycles", 32'(n), 20);

      // Test 2: descending
      use_desc = 1'b1;
      push(9, 1, 0); push(3, 0, 0); push(3, 2, 0); push(1, 3, 1);
      load(3, 9, 3, 1, 4'b1111);
      wait_idle("t2_done");
      use_desc = 1'b0;

      // Test 4: empty mask
      load(5, 6, 7, 8, 4'b0000);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t4_ready", 32'(o_ready), 1);
         chk("t4_valid", 32'(o_valid), 0);
      end

      // Test 3: partial mask, following the empty batch
      push(7, 2, 0); push(15, 1, 1);
      load(0, 15, 7, 0, 4'b0110);
      wait_idle("t3_done");

      // Test 5: backpressure on the 2nd element
      push(1, 3, 0); push(3, 0, 0); push(3, 2, 0); push(9, 1, 1);
      load(3, 9, 3, 1, 4'b1111);
      wait_valid("t5_first");
      @(posedge clk);
      #1 i_ready = 1'b0;
      wait_valid("t5_second");
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(o_valid), 1);
         chk("stall_key", 32'(o_key), 3);
         chk("stall_idx", 32'(o_idx), 0);
         chk("stall_ready", 32'(o_ready), 0);
         @(negedge clk);
      end
      i_ready = 1'b1;
      wait_idle("t5_done");

      // Test 6: reset during the 3rd element's scan
      push(1, 3, 0); push(3, 0, 0);
      load(3, 9, 3, 1, 4'b1111);
      repeat (11) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t6_ready", 32'(o_ready), 1);
      chk("t6_busy", 32'(o_busy), 0);
      chk("t6_valid", 32'(o_valid), 0);
      chk("t6_key", 32'(o_key), 0);
      repeat (10) @(negedge clk);
      push(2, 0, 0); push(2, 1, 0); push(2, 2, 0); push(2, 3, 1);
      load(2, 2, 2, 2, 4'b1111);
      wait_idle("t6_done");

      repeat (3) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
